// File: rtl/ibex_pmu_arbiter.sv
// ibex_pmu_arbiter: round-robin share of one PMU counter port among
// NUM_REQ requesters, one transaction outstanding. Optional WFP
// timeout is compiled in with `define IBEX_PMU_ARB_TIMEOUT_EN.
//
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   req_op_i[n]          2'd0 PMC_IDLE, 2'd1 PMC_REQ, 2'd2 PMC_WFP
//   req_addr_i[n]        counter address
//   req_we_i[n]          write enable
//   req_wdata_i[n]       write data
//   req_gnt_o            accept strobe, one-hot or zero
//   req_rvalid_o         response strobe to owner, one-hot or zero
//   req_err_o            response error (valid with req_rvalid_o)
//   req_rdata_o          response data (valid with req_rvalid_o)
//   pmu_op_o/addr/we/wdata  request to the shared PMU port
//   pmu_gnt_i            PMU ready
//   pmu_rvalid_i/err/rdata  PMU response
//   spurious_o           pulse: response seen while idle
module ibex_pmu_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_REQ-1:0][1:0]  req_op_i,
  input  logic [NUM_REQ-1:0][31:0] req_addr_i,
  input  logic [NUM_REQ-1:0]       req_we_i,
  input  logic [NUM_REQ-1:0][31:0] req_wdata_i,
  output logic [NUM_REQ-1:0]       req_gnt_o,
  output logic [NUM_REQ-1:0]       req_rvalid_o,
  output logic                     req_err_o,
  output logic [31:0]              req_rdata_o,
  output logic [1:0]               pmu_op_o,
  output logic [31:0]              pmu_addr_o,
  output logic                     pmu_we_o,
  output logic [31:0]              pmu_wdata_o,
  input  logic                     pmu_gnt_i,
  input  logic                     pmu_rvalid_i,
  input  logic                     pmu_err_i,
  input  logic [31:0]              pmu_rdata_i,
  output logic                     spurious_o
);

  localparam logic [1:0] PMC_IDLE = 2'd0;
  localparam logic [1:0] PMC_WFP  = 2'd2;

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  localparam logic [IdxW:0]   NumReq  = (IdxW+1)'(NUM_REQ);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REQ - 1);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [1:0]      op_q, op_d;
  logic [31:0]     addr_q, addr_d;
  logic            we_q, we_d;
  logic [31:0]     wdata_q, wdata_d;

`ifdef IBEX_PMU_ARB_TIMEOUT_EN
  localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [TmrW-1:0] TmoLast =
    TmrW'(TIMEOUT_CYCLES - 1);

  logic [TmrW-1:0] timer_q, timer_d;
`endif

  logic            win_found;
  logic [IdxW-1:0] win_idx;
  logic [IdxW:0]   cand;
  logic [IdxW-1:0] nxt_ptr;

  // First active requester at or after rr_ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + (IdxW+1)'(i);
      if (cand >= NumReq) begin
        cand = cand - NumReq;
      end
      if (!win_found &&
          req_op_i[cand[IdxW-1:0]] != PMC_IDLE) begin
        win_found = 1'b1;
        win_idx   = cand[IdxW-1:0];
      end
    end
  end

  // Pointer after a completion: the requester after the owner.
  always_comb begin
    if (owner_q == LastIdx) begin
      nxt_ptr = '0;
    end else begin
      nxt_ptr = owner_q + 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    op_d         = op_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
`ifdef IBEX_PMU_ARB_TIMEOUT_EN
    timer_d      = timer_q;
`endif
    req_gnt_o    = '0;
    req_rvalid_o = '0;
    req_err_o    = pmu_err_i;
    req_rdata_o  = pmu_rdata_i;
    pmu_op_o     = PMC_IDLE;
    pmu_addr_o   = '0;
    pmu_we_o     = 1'b0;
    pmu_wdata_o  = '0;
    spurious_o   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        spurious_o = pmu_rvalid_i;
        if (win_found) begin
          pmu_op_o    = req_op_i[win_idx];
          pmu_addr_o  = req_addr_i[win_idx];
          pmu_we_o    = req_we_i[win_idx];
          pmu_wdata_o = req_wdata_i[win_idx];
          if (pmu_gnt_i) begin
            req_gnt_o[win_idx] = 1'b1;
            owner_d = win_idx;
            op_d    = req_op_i[win_idx];
            addr_d  = req_addr_i[win_idx];
            we_d    = req_we_i[win_idx];
            wdata_d = req_wdata_i[win_idx];
            state_d = S_BUSY;
`ifdef IBEX_PMU_ARB_TIMEOUT_EN
            timer_d = '0;
`endif
          end
        end
      end

      S_BUSY: begin
        // A WFP keeps the port claimed until it resolves.
        if (op_q == PMC_WFP) begin
          pmu_op_o    = PMC_WFP;
          pmu_addr_o  = addr_q;
          pmu_we_o    = we_q;
          pmu_wdata_o = wdata_q;
        end
        if (pmu_rvalid_i) begin
          req_rvalid_o[owner_q] = 1'b1;
          rr_ptr_d = nxt_ptr;
          state_d  = S_IDLE;
        end
`ifdef IBEX_PMU_ARB_TIMEOUT_EN
        else if (op_q == PMC_WFP) begin
          if (timer_q == TmoLast) begin
            // Abort: synthesize an error response, drop the WFP.
            req_rvalid_o[owner_q] = 1'b1;
            req_err_o   = 1'b1;
            req_rdata_o = '0;
            pmu_op_o    = PMC_IDLE;
            pmu_addr_o  = '0;
            pmu_we_o    = 1'b0;
            pmu_wdata_o = '0;
            rr_ptr_d    = nxt_ptr;
            state_d     = S_IDLE;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
`endif
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      op_q     <= PMC_IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
    end
  end

`ifdef IBEX_PMU_ARB_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`endif

endmodule

// File: tb/tb_ibex_pmu_arbiter.sv
// tb_ibex_pmu_arbiter: directed bench for ibex_pmu_arbiter with
// a transaction-level reference model checked every cycle.
module tb_ibex_pmu_arbiter;

  localparam int N   = 2;
  localparam int TMO = 16;
`ifdef IBEX_PMU_ARB_TIMEOUT_EN
  localparam bit TMO_EN  = 1'b1;
  localparam int WFP_LEN = 12;
`else
  localparam bit TMO_EN  = 1'b0;
  localparam int WFP_LEN = 50;
`endif

  localparam logic [1:0] OP_IDLE = 2'd0;
  localparam logic [1:0] OP_REQ  = 2'd1;
  localparam logic [1:0] OP_WFP  = 2'd2;

  logic                clk;
  logic                rst_ni;
  logic [N-1:0][1:0]   req_op_i;
  logic [N-1:0][31:0]  req_addr_i;
  logic [N-1:0]        req_we_i;
  logic [N-1:0][31:0]  req_wdata_i;
  logic [N-1:0]        req_gnt_o;
  logic [N-1:0]        req_rvalid_o;
  logic                req_err_o;
  logic [31:0]         req_rdata_o;
  logic [1:0]          pmu_op_o;
  logic [31:0]         pmu_addr_o;
  logic                pmu_we_o;
  logic [31:0]         pmu_wdata_o;
  logic                pmu_gnt_i;
  logic                pmu_rvalid_i;
  logic                pmu_err_i;
  logic [31:0]         pmu_rdata_i;
  logic                spurious_o;

  ibex_pmu_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .req_op_i     (req_op_i),
    .req_addr_i   (req_addr_i),
    .req_we_i     (req_we_i),
    .req_wdata_i  (req_wdata_i),
    .req_gnt_o    (req_gnt_o),
    .req_rvalid_o (req_rvalid_o),
    .req_err_o    (req_err_o),
    .req_rdata_o  (req_rdata_o),
    .pmu_op_o     (pmu_op_o),
    .pmu_addr_o   (pmu_addr_o),
    .pmu_we_o     (pmu_we_o),
    .pmu_wdata_o  (pmu_wdata_o),
    .pmu_gnt_i    (pmu_gnt_i),
    .pmu_rvalid_i (pmu_rvalid_i),
    .pmu_err_i    (pmu_err_i),
    .pmu_rdata_i  (pmu_rdata_i),
    .spurious_o   (spurious_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(string nm, logic [31:0] act,
                       logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // Transaction view: a port is either free or owned by one
  // requester; m_n counts how many owned cycles have elapsed.
  bit m_busy  = 1'b0;
  bit m_wfp   = 1'b0;
  int m_ptr   = 0;
  int m_owner = 0;
  int m_n     = 0;

  function automatic int winner(int ptr);
    for (int i = 0; i < N; i++) begin
      int k;
      k = (ptr + i) % N;
      if (req_op_i[k] != OP_IDLE) return k;
    end
    return -1;
  endfunction

  always @(negedge clk) begin : cmp
    logic [N-1:0] e_gnt, e_rv;
    logic [1:0]   e_op;
    logic [31:0]  e_addr, e_wdata, e_rdata;
    logic         e_we, e_err, e_spur;
    bit           chk_req, done, bad;
    int           w;
    e_gnt = '0; e_rv = '0; e_op = OP_IDLE;
    e_addr = '0; e_wdata = '0; e_we = 1'b0;
    e_rdata = '0; e_err = 1'b0; e_spur = 1'b0;
    chk_req = 1'b0; done = 1'b0;
    if (!rst_ni) begin
      m_busy = 1'b0; m_ptr = 0; m_owner = 0; m_n = 0;
      chk_req = 1'b1;
    end else if (!m_busy) begin
      chk_req = 1'b1;
      e_spur  = pmu_rvalid_i;
      w = winner(m_ptr);
      if (w >= 0) begin
        e_op    = req_op_i[w];
        e_addr  = req_addr_i[w];
        e_we    = req_we_i[w];
        e_wdata = req_wdata_i[w];
        if (pmu_gnt_i) begin
          e_gnt[w] = 1'b1;
          m_busy   = 1'b1;
          m_owner  = w;
          m_wfp    = (req_op_i[w] == OP_WFP);
          m_n      = 0;
        end
      end
    end else begin
      m_n++;
      e_op = m_wfp ? OP_WFP : OP_IDLE;
      if (pmu_rvalid_i) begin
        e_rv[m_owner] = 1'b1;
        e_rdata = pmu_rdata_i;
        e_err   = pmu_err_i;
        done    = 1'b1;
      end else if (TMO_EN && m_wfp && m_n == TMO) begin
        e_rv[m_owner] = 1'b1;
        e_rdata = '0;
        e_err   = 1'b1;
        e_op    = OP_IDLE;
        done    = 1'b1;
      end
      if (done) begin
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % N;
      end
    end
    bad = (req_gnt_o !== e_gnt) || (req_rvalid_o !== e_rv) ||
          (pmu_op_o !== e_op) || (spurious_o !== e_spur);
    if (e_rv != '0)
      bad = bad || (req_rdata_o !== e_rdata) ||
            (req_err_o !== e_err);
    if (chk_req)
      bad = bad || (pmu_addr_o !== e_addr) ||
            (pmu_we_o !== e_we) || (pmu_wdata_o !== e_wdata);
    n_run++;
    if (bad) begin
      n_fail++;
      $display("FAIL cycle t=%0t gnt %b/%b rv %b/%b op %0d/%0d spur %b/%b rdata %0h/%0h err %b/%b addr %0h/%0h (got/exp)",
               $time, req_gnt_o, e_gnt, req_rvalid_o, e_rv,
               pmu_op_o, e_op, spurious_o, e_spur,
               req_rdata_o, e_rdata, req_err_o, e_err,
               pmu_addr_o, e_addr);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  int gq[$];
  int exp_seq[4] = '{0, 1, 0, 1};
  int cnt;
  int got;

  task automatic all_idle();
    req_op_i    = '0;
    req_addr_i  = '0;
    req_we_i    = '0;
    req_wdata_i = '0;
  endtask

  initial begin
    rst_ni       = 1'b0;
    all_idle();
    pmu_gnt_i    = 1'b0;
    pmu_rvalid_i = 1'b0;
    pmu_err_i    = 1'b0;
    pmu_rdata_i  = '0;
    repeat (2) cyc();
    check("rst_gnt", 32'(req_gnt_o), 32'h0);
    check("rst_op", 32'(pmu_op_o), 32'(OP_IDLE));
    rst_ni = 1'b1;
    cyc();

    // 1: single read from requester 0, PMU stalls one cycle first
    req_op_i[0]   = OP_REQ;
    req_addr_i[0] = 32'h10;
    #1;
    check("t1_nogate", 32'(req_gnt_o), 32'h0);
    check("t1_present", 32'(pmu_op_o), 32'(OP_REQ));
    cyc();
    pmu_gnt_i = 1'b1;
    #1;
    check("t1_gnt", 32'(req_gnt_o), 32'h1);
    check("t1_addr", pmu_addr_o, 32'h10);
    cyc();
    all_idle();
    cyc();
    cyc();
    pmu_rvalid_i = 1'b1;
    pmu_rdata_i  = 32'hA5A5_0001;
    #1;
    check("t1_rv", 32'(req_rvalid_o), 32'h1);
    check("t1_rdata", req_rdata_o, 32'hA5A5_0001);
    check("t1_err", 32'(req_err_o), 32'h0);
    cyc();
    pmu_rvalid_i = 1'b0;

    // reset so rr_ptr starts at 0
    rst_ni = 1'b0;
    cyc();
    rst_ni = 1'b1;
    cyc();

    // 2: both requesters contend continuously
    req_op_i[0]   = OP_REQ;
    req_op_i[1]   = OP_REQ;
    req_addr_i[0] = 32'h100;
    req_addr_i[1] = 32'h200;
    req_we_i[1]   = 1'b1;
    req_wdata_i[1] = 32'hDEAD_BEEF;
    for (int k = 0; k < 4; k++) begin
      #1;
      gq.push_back(req_gnt_o[1] ? 1 : (req_gnt_o[0] ? 0 : -1));
      cyc();
      check("t2_busy_nognt", 32'(req_gnt_o), 32'h0);
      cyc();
      pmu_rvalid_i = 1'b1;
      pmu_rdata_i  = 32'(k);
      #1;
      check("t2_rv_nognt", 32'(req_gnt_o), 32'h0);
      cyc();
      pmu_rvalid_i = 1'b0;
    end
    for (int k = 0; k < 4; k++)
      check("t2_order", 32'(gq[k]), 32'(exp_seq[k]));
    all_idle();
    cyc();

    // 3: requester 1 WFP, requester 0 waits behind it
    req_op_i[1]   = OP_WFP;
    req_addr_i[1] = 32'h44;
    #1;
    check("t3_gnt", 32'(req_gnt_o), 32'h2);
    cyc();
    all_idle();
    req_op_i[0]   = OP_REQ;
    req_addr_i[0] = 32'h8;
    cnt = 0;
    for (int i = 1; i <= WFP_LEN; i++) begin
      if (i == WFP_LEN) begin
        pmu_rvalid_i = 1'b1;
        pmu_rdata_i  = 32'h0000_0033;
      end
      #1;
      if (pmu_op_o == OP_WFP && req_gnt_o == '0) cnt++;
      if (i == WFP_LEN)
        check("t3_rv", 32'(req_rvalid_o), 32'h2);
      cyc();
    end
    check("t3_wfp_cycles", 32'(cnt), 32'(WFP_LEN));
    pmu_rvalid_i = 1'b0;
    #1;
    check("t3_next_gnt", 32'(req_gnt_o), 32'h1);
    cyc();
    all_idle();
    cyc();
    pmu_rvalid_i = 1'b1;
    cyc();
    pmu_rvalid_i = 1'b0;

    // 4: stray response while idle; pointer left at 1
    pmu_rvalid_i = 1'b1;
    pmu_rdata_i  = 32'h7777;
    #1;
    check("t4_spur", 32'(spurious_o), 32'h1);
    check("t4_norv", 32'(req_rvalid_o), 32'h0);
    cyc();
    pmu_rvalid_i = 1'b0;
    #1;
    check("t4_spur_clr", 32'(spurious_o), 32'h0);
    req_op_i[0] = OP_REQ;
    req_op_i[1] = OP_REQ;
    #1;
    check("t4_ptr_kept", 32'(req_gnt_o), 32'h2);
    cyc();
    all_idle();
    pmu_rvalid_i = 1'b1;
    cyc();
    pmu_rvalid_i = 1'b0;

    // 5: reset while a WFP is outstanding
    req_op_i[1] = OP_WFP;
    #1;
    check("t5_gnt", 32'(req_gnt_o), 32'h2);
    cyc();
    all_idle();
    cyc();
    cyc();
    rst_ni = 1'b0;
    #1;
    check("t5_rst_op", 32'(pmu_op_o), 32'(OP_IDLE));
    check("t5_rst_rv", 32'(req_rvalid_o), 32'h0);
    cyc();
    rst_ni = 1'b1;
    pmu_rvalid_i = 1'b1;
    #1;
    check("t5_late_spur", 32'(spurious_o), 32'h1);
    cyc();
    pmu_rvalid_i = 1'b0;
    req_op_i[1]  = OP_REQ;
    #1;
    check("t5_fresh_gnt", 32'(req_gnt_o), 32'h2);
    cyc();
    all_idle();
    pmu_rvalid_i = 1'b1;
    cyc();
    pmu_rvalid_i = 1'b0;

`ifdef IBEX_PMU_ARB_TIMEOUT_EN
    // 6a: WFP never answered -> synthesized error response
    req_op_i[0] = OP_WFP;
    #1;
    check("t6_gnt", 32'(req_gnt_o), 32'h1);
    cyc();
    all_idle();
    pmu_rdata_i = 32'hFFFF_FFFF;
    got = 0;
    for (int i = 1; i <= 40 && got == 0; i++) begin
      #1;
      if (req_rvalid_o != '0) begin
        got = i;
        check("t6_tmo_err", 32'(req_err_o), 32'h1);
        check("t6_tmo_rdata", req_rdata_o, 32'h0);
        check("t6_tmo_op", 32'(pmu_op_o), 32'(OP_IDLE));
      end
      cyc();
    end
    check("t6_tmo_cycle", 32'(got), 32'(TMO));
    pmu_rvalid_i = 1'b1;
    #1;
    check("t6_late_spur", 32'(spurious_o), 32'h1);
    cyc();
    pmu_rvalid_i = 1'b0;

    // 6b: response lands in the timeout cycle
    req_op_i[0] = OP_WFP;
    cyc();
    all_idle();
    repeat (TMO - 1) cyc();
    pmu_rvalid_i = 1'b1;
    pmu_err_i    = 1'b0;
    pmu_rdata_i  = 32'h1234;
    #1;
    check("t6_race_rv", 32'(req_rvalid_o), 32'h1);
    check("t6_race_err", 32'(req_err_o), 32'h0);
    check("t6_race_rdata", req_rdata_o, 32'h1234);
    cyc();
    pmu_rvalid_i = 1'b0;
`endif

    cyc();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
